subneg_mem_responder: RTL and testbench
=======================================

Name: subneg_mem_responder

Overview:
- Memory-side responder for the SUBNEG core's external bus: emulates the address latch, a 256x8 SRAM and the output latch that the core drives.
- Captures addresses on latch strobes, returns read data while output-enable is low, and commits writes on write-enable pulses.
- Adds a host load/inspect port for program preload, activity counters and protocol-error flags.
- Sits in the FPGA/bench top opposite the core, connected to the core's shared 8-bit bus and its strobe outputs.

Parameters:
- DATA_W, 8, bus and memory word width
- ADDR_W, 8, address width; memory depth 2**ADDR_W
- CNT_W, 16, width of the read and write activity counters

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- bus_in  in  DATA_W  bus value driven by the core
- cpu_drive  in  1  core bus output-enable; 1 = core drives the bus
- latch_clk  in  1  address latch strobe; rising edge captures the address
- mem_oe_n  in  1  SRAM output enable, active low
- mem_we_n  in  1  SRAM write enable, active low
- out_latch_clk  in  1  output latch strobe; rising edge captures the bus
- bus_out  out  DATA_W  read data returned to the core
- bus_drive  out  1  responder drives the bus (= ~mem_oe_n while host_sel=0)
- out_value  out  DATA_W  last captured output-port value
- out_valid  out  1  one-cycle pulse when out_value updates
- host_sel  in  1  1 = host owns memory; core strobes are ignored
- host_we  in  1  host write strobe
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  mem[host_addr], combinational
- rd_count  out  CNT_W  completed core reads, saturating
- wr_count  out  CNT_W  completed core writes, saturating
- contention  out  1  sticky: mem_oe_n=0 while cpu_drive=1
- proto_err  out  1  sticky: OE or WE asserted in IDLE (no address latched)

Behaviour:
- Decided interface: reset reset, synchronous, active-high; clock clk. All state changes on posedge clk.
- Edge detection:
  - Registered copies of latch_clk, mem_we_n and out_latch_clk.
  - During reset the copies load the current pin levels, so no false edge fires on release.
- Reset values:
  - Internal addr_q=0, FSM=IDLE.
  - out_value=0, out_valid=0, rd_count=0, wr_count=0, contention=0, proto_err=0.
  - Memory array is not reset; it keeps its contents through reset.
- FSM states IDLE, ADDR, READ, WRITE. Core strobes are ignored while host_sel=1; the FSM holds its state.
  - IDLE/ADDR/READ: latch rise -> addr_q<=bus_in, go to ADDR. A latch rise in WRITE is also taken: addr_q<=bus_in, go to ADDR. A latch rise always wins over other transitions in the same cycle.
  - ADDR: mem_oe_n=0 -> READ. WE fall -> WRITE, with mem[addr_q]<=bus_in in that cycle.
  - READ: mem_oe_n rises -> rd_count+1, return to ADDR.
  - WRITE: mem_we_n rises -> wr_count+1, return to ADDR.
- Read timing:
  - bus_out=mem[addr_q], combinational from the flop array.
  - Data is valid in the cycle after the latch rise is detected, which meets the core's sample one cycle after OE falls.
- Write rules:
  - Exactly one write per WE low pulse, on the falling edge, using the address latched last.
  - WE held low for several cycles does not rewrite.
- Output latch:
  - out_latch_clk rise -> out_value<=bus_in and out_valid=1 for one cycle. This is independent of the FSM.
  - The core never writes SRAM to address 255 (that address is the output port). The responder does not special-case it; it is simply not written.
- Host port:
  - host_sel=1 and host_we=1 -> mem[host_addr]<=host_wdata.
  - If the core strobes during host_sel=1, they are ignored and proto_err is not set.
- Counters saturate at all-ones.
- contention and proto_err are sticky and cleared only by reset.
- Reset mid-transaction: the FSM returns to IDLE and any pending count increment is lost; a write already committed to memory remains.

Decomposition:
- Package subneg_bus_pkg:
  - DATA_W and ADDR_W constants.
  - OUT_PORT_ADDR=8'hFF.
  - Idle strobe levels: latch 0, oe_n 1, we_n 1.
  - resp_state_t enum {IDLE, ADDR, READ, WRITE}.
- Sub-module strobe_edge_det: one registered copy with rise/fall outputs and reset-load of the current level. Instantiated three times.

Test Plan:
- Host preload: host_sel=1, write mem[8'h10]=8'h3C -> host_rdata=8'h3C; no count changes.
- Read: bus_in=8'h10, latch pulse, OE low one cycle -> bus_out=8'h3C in the cycle after the latch rise; rd_count=1; FSM IDLE->ADDR->READ->ADDR.
- Write: latch addr 8'h20, bus_in=8'hF7, WE low 2 cycles -> mem[8'h20]=8'hF7 written once; wr_count=1.
- Output port: bus_in=8'h5A, out_latch_clk rises -> out_value=8'h5A with out_valid high exactly one cycle; no memory change.
- Errors:
  - OE low straight after reset with no latch -> proto_err=1.
  - OE low while cpu_drive=1 -> contention=1; both flags stay set until reset.
- Reset with latch_clk held high across release -> no address capture; FSM stays IDLE; a later full cycle from 0 works normally.

Source files
------------

// File: rtl/subneg_bus_pkg.sv
// rtl/subneg_bus_pkg.sv - shared constants and state type for the SUBNEG memory responder
package subneg_bus_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  // The core treats this address as its output port and never stores to it.
  localparam logic [7:0] OUT_PORT_ADDR = 8'hFF;

  localparam logic IDLE_LATCH = 1'b0;
  localparam logic IDLE_OE_N  = 1'b1;
  localparam logic IDLE_WE_N  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } resp_state_t;

endpackage

// File: rtl/subneg_mem_responder_if.sv
// rtl/subneg_mem_responder_if.sv - core-side bus and strobes between SUBNEG core and memory responder
interface subneg_mem_responder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] bus_in;
  logic              cpu_drive;
  logic              latch_clk;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic              out_latch_clk;
  logic [DATA_W-1:0] bus_out;
  logic              bus_drive;

  modport master (
    output bus_in, cpu_drive, latch_clk, mem_oe_n, mem_we_n, out_latch_clk,
    input  bus_out, bus_drive
  );

  modport slave (
    input  bus_in, cpu_drive, latch_clk, mem_oe_n, mem_we_n, out_latch_clk,
    output bus_out, bus_drive
  );

endinterface

// File: rtl/strobe_edge_det.sv
// rtl/strobe_edge_det.sv - single-register edge detector for an external strobe
// The copy loads the live level during reset so no false edge fires on release.
module strobe_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk) begin
    sig_q <= sig;
  end

  assign rise = ~reset & sig & ~sig_q;
  assign fall = ~reset & ~sig & sig_q;

endmodule

// File: rtl/subneg_mem_responder.sv
// rtl/subneg_mem_responder.sv - address latch, 256x8 SRAM and output latch seen by the SUBNEG core
// Adds a host preload/inspect port, saturating activity counters and sticky protocol flags.
module subneg_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  subneg_mem_responder_if.slave bus,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  input  logic              host_sel,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              contention,
  output logic              proto_err
);

  import subneg_bus_pkg::*;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] addr_q;
  resp_state_t       state;

  logic latch_rise, latch_fall;
  logic we_rise, we_fall;
  logic out_rise, out_fall;
  logic core_wr;
  logic unused_edges;

  strobe_edge_det u_latch_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.latch_clk),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  strobe_edge_det u_we_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.mem_we_n),
    .rise  (we_rise),
    .fall  (we_fall)
  );

  strobe_edge_det u_out_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.out_latch_clk),
    .rise  (out_rise),
    .fall  (out_fall)
  );

  assign unused_edges = latch_fall ^ out_fall;

  // One store per WE pulse: only the falling edge out of ADDR commits, and a latch rise pre-empts it.
  assign core_wr = ~host_sel & ~latch_rise & (state == ADDR) & bus.mem_oe_n & we_fall;

  always_ff @(posedge clk) begin
    if (host_sel && host_we) begin
      mem[host_addr] <= host_wdata;
    end else if (core_wr) begin
      mem[addr_q] <= bus.bus_in;
    end
  end

  assign bus.bus_out   = mem[addr_q];
  assign bus.bus_drive = ~host_sel & ~bus.mem_oe_n;
  assign host_rdata    = mem[host_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      contention <= 1'b0;
      proto_err  <= 1'b0;
    end else if (!host_sel) begin
      if (!bus.mem_oe_n && bus.cpu_drive) begin
        contention <= 1'b1;
      end
      if (state == IDLE && (!bus.mem_oe_n || !bus.mem_we_n)) begin
        proto_err <= 1'b1;
      end

      if (latch_rise) begin
        addr_q <= ADDR_W'(bus.bus_in);
        state  <= ADDR;
      end else begin
        case (state)
          ADDR: begin
            if (!bus.mem_oe_n) begin
              state <= READ;
            end else if (we_fall) begin
              state <= WRITE;
            end
          end
          READ: begin
            if (bus.mem_oe_n) begin
              state <= ADDR;
              if (rd_count != '1) rd_count <= rd_count + 1'b1;
            end
          end
          WRITE: begin
            if (we_rise) begin
              state <= ADDR;
              if (wr_count != '1) wr_count <= wr_count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_value <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_rise;
      if (out_rise) out_value <= bus.bus_in;
    end
  end

endmodule

// File: tb/tb_subneg_mem_responder.sv
// tb/tb_subneg_mem_responder.sv - scoreboard bench for the SUBNEG memory responder
module tb_subneg_mem_responder;

  import subneg_bus_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] out_value;
  logic       out_valid;
  logic       host_sel;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic       contention;
  logic       proto_err;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [7:0] exp_rd_q [$];
  logic [7:0] exp_out_q [$];

  subneg_mem_responder_if #(.DATA_W(8)) bus_if ();

  subneg_mem_responder #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .host_sel   (host_sel),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .contention (contention),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic core_read(input logic [7:0] a, input logic [7:0] exp);
    exp_rd_q.push_back(exp);
    bus_if.bus_in    = a;
    bus_if.latch_clk = 1'b1;
    tick();
    check_eq("rd_after_latch", bus_if.bus_out, exp);
    bus_if.latch_clk = 1'b0;
    bus_if.mem_oe_n  = 1'b0;
    tick();
    bus_if.mem_oe_n  = 1'b1;
    tick();
    exp_rd++;
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.bus_in    = a;
    bus_if.latch_clk = 1'b1;
    tick();
    bus_if.latch_clk = 1'b0;
    bus_if.bus_in    = d;
    bus_if.mem_we_n  = 1'b0;
    tick();
    bus_if.bus_in    = ~d;
    tick();
    bus_if.mem_we_n  = 1'b1;
    tick();
    exp_wr++;
  endtask

  // Scoreboard side: read data is compared while the responder drives the bus.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_out_q.size() == 0) check_eq("out_spurious", {31'd0, out_valid}, 32'd0);
      else check_eq("out_value", out_value, exp_out_q.pop_front());
    end
    if (bus_if.bus_drive && exp_rd_q.size() != 0) begin
      check_eq("rd_data", bus_if.bus_out, exp_rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;

    reset                = 1'b1;
    host_sel             = 1'b0;
    host_we              = 1'b0;
    host_addr            = 8'h00;
    host_wdata           = 8'h00;
    bus_if.bus_in        = 8'h00;
    bus_if.cpu_drive     = 1'b0;
    bus_if.latch_clk     = IDLE_LATCH;
    bus_if.mem_oe_n      = IDLE_OE_N;
    bus_if.mem_we_n      = IDLE_WE_N;
    bus_if.out_latch_clk = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check_eq("rst_rd_count", rd_count, 0);
    check_eq("rst_wr_count", wr_count, 0);
    check_eq("rst_out_value", out_value, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_contention", contention, 0);
    check_eq("rst_proto_err", proto_err, 0);

    // Host preload, then core strobes while the host owns memory must be ignored.
    host_sel   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h10;
    host_wdata = 8'h3C;
    tick();
    host_we = 1'b0;
    check_eq("host_rdata_10", host_rdata, 8'h3C);
    bus_if.bus_in    = 8'h55;
    bus_if.latch_clk = 1'b1;
    bus_if.mem_oe_n  = 1'b0;
    tick();
    tick();
    bus_if.latch_clk = 1'b0;
    bus_if.mem_oe_n  = 1'b1;
    tick();
    check_eq("host_proto_err", proto_err, 0);
    check_eq("host_rd_count", rd_count, 0);
    check_eq("host_wr_count", wr_count, 0);
    host_sel = 1'b0;
    tick();

    core_read(8'h10, 8'h3C);
    check_eq("rd_count_1", rd_count, exp_rd);
    check_eq("wr_count_0", wr_count, exp_wr);

    core_write(8'h20, 8'hF7);
    host_addr = 8'h20;
    check_eq("wr_once_20", host_rdata, 8'hF7);
    check_eq("wr_count_1", wr_count, exp_wr);
    core_read(8'h20, 8'hF7);

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, int'(OUT_PORT_ADDR) - 1));
      if (a == 8'h10) a = 8'h11;
      d = 8'($urandom_range(0, 255));
      core_write(a, d);
      core_read(a, d);
    end
    check_eq("rd_count_loop", rd_count, exp_rd);
    check_eq("wr_count_loop", wr_count, exp_wr);

    // Output port: held strobe yields one pulse per rising edge.
    exp_out_q.push_back(8'h5A);
    bus_if.bus_in        = 8'h5A;
    bus_if.out_latch_clk = 1'b1;
    tick();
    check_eq("out_valid_hi", out_valid, 1);
    tick();
    check_eq("out_valid_one", out_valid, 0);
    tick();
    bus_if.out_latch_clk = 1'b0;
    tick();
    exp_out_q.push_back(8'hA5);
    bus_if.bus_in        = 8'hA5;
    bus_if.out_latch_clk = 1'b1;
    tick();
    bus_if.out_latch_clk = 1'b0;
    bus_if.bus_in        = 8'h00;
    tick();
    check_eq("out_value_hold", out_value, 8'hA5);
    host_addr = 8'h10;
    check_eq("out_no_mem", host_rdata, 8'h3C);
    check_eq("out_rd_count", rd_count, exp_rd);
    check_eq("clean_proto_err", proto_err, 0);
    check_eq("clean_contention", contention, 0);

    // Error flags after reset; memory survives reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_eq("mem_kept", host_rdata, 8'h3C);
    check_eq("err_proto_pre", proto_err, 0);
    bus_if.mem_oe_n = 1'b0;
    tick();
    check_eq("err_proto_set", proto_err, 1);
    check_eq("err_cont_clear", contention, 0);
    bus_if.cpu_drive = 1'b1;
    tick();
    check_eq("err_cont_set", contention, 1);
    bus_if.mem_oe_n  = 1'b1;
    bus_if.cpu_drive = 1'b0;
    tick();
    tick();
    check_eq("err_proto_sticky", proto_err, 1);
    check_eq("err_cont_sticky", contention, 1);

    // Latch held high across reset release must not capture an address.
    reset            = 1'b1;
    bus_if.bus_in    = 8'h33;
    bus_if.latch_clk = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("hold_proto_clear", proto_err, 0);
    check_eq("hold_cont_clear", contention, 0);
    check_eq("hold_rd_count", rd_count, 0);
    bus_if.mem_oe_n = 1'b0;
    tick();
    check_eq("hold_still_idle", proto_err, 1);
    bus_if.mem_oe_n = 1'b1;
    tick();
    bus_if.latch_clk = 1'b0;
    tick();
    exp_rd = 0;
    core_read(8'h10, 8'h3C);
    check_eq("hold_rd_after", rd_count, exp_rd);

    tick();
    check_eq("rd_q_left", exp_rd_q.size(), 0);
    check_eq("out_q_left", exp_out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
